// File: rtl/post_pkg.sv
// post_pkg: shared definitions for the disparity post-processing frame controller.
// Holds the controller state encoding, the datapath field widths and a helper that
// computes the pixel count of a frame.
package post_pkg;

    localparam int unsigned DwidthDefault = 16; // disparity word width
    localparam int unsigned DimW          = 11; // frame width/height and pixel position
    localparam int unsigned RangeW        = 9;  // disparity search range
    localparam int unsigned LrcW          = 18; // left-right check threshold, 10.8 fixed point
    localparam int unsigned CntW          = 2 * DimW; // width*height product

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRun,
        StDrain,
        StDone
    } state_e;

    // Total pixels in a width x height frame; the full product always fits in CntW bits.
    function automatic logic [CntW-1:0] frame_pixels(input logic [DimW-1:0] w,
                                                     input logic [DimW-1:0] h);
        return CntW'(w) * CntW'(h);
    endfunction

endpackage

// File: rtl/post_pix_counter.sv
// post_pix_counter: raster column/row position counter for the output stream.
// Ports:
//   clk_i, rst_ni      clock and asynchronous active-low reset
//   clr_i              synchronous clear back to (0,0)
//   adv_i              advance one pixel
//   width_i, height_i  frame size (both nonzero while advancing)
//   col_o, row_o       current position
//   last_o             current position is the final pixel of the frame
module post_pix_counter
    import post_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clr_i,
    input  logic            adv_i,
    input  logic [DimW-1:0] width_i,
    input  logic [DimW-1:0] height_i,
    output logic [DimW-1:0] col_o,
    output logic [DimW-1:0] row_o,
    output logic            last_o
);

    logic [DimW-1:0] col_q, col_d;
    logic [DimW-1:0] row_q, row_d;
    logic            col_end;
    logic            row_end;

    assign col_end = (col_q == width_i - DimW'(1));
    assign row_end = (row_q == height_i - DimW'(1));
    assign last_o  = col_end && row_end;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clr_i) begin
            col_d = '0;
            row_d = '0;
        end else if (adv_i) begin
            if (col_end) begin
                col_d = '0;
                // Wrap fully after the last pixel so the position never leaves the frame.
                row_d = row_end ? '0 : row_q + DimW'(1);
            end else begin
                col_d = col_q + DimW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col_o = col_q;
    assign row_o = row_q;

endmodule

// File: rtl/post_frame_ctrl.sv
// post_frame_ctrl: frame sequencer for the disparity post-processing datapath.
// Latches the requested configuration on start, enables the datapath while the
// frame streams through, counts input pixels, tracks the output position and
// aborts the drain phase if the datapath stops producing pixels for too long.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   start                         frame start pulse (honoured in idle only)
//   cfg_*                         requested frame size and datapath configuration
//   in_valid_L, in_valid_R        disparity input strobes (left view paces the frame)
//   out_valid, ds_ready           final output strobe, downstream ready
//   clken, enable                 datapath clock-enable and enable
//   width .. sel_col              shadowed configuration driven to the datapath
//   busy, done, err_timeout       status; done is a one-cycle pulse, error is sticky
//   out_row, out_col              position of the next output pixel
module post_frame_ctrl
    import post_pkg::*;
#(
    parameter int unsigned DWIDTH  = DwidthDefault,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DimW-1:0]   cfg_width,
    input  logic [DimW-1:0]   cfg_height,
    input  logic [RangeW-1:0] cfg_range,
    input  logic [LrcW-1:0]   cfg_lrc_param,
    input  logic              cfg_pp_sel,
    input  logic              cfg_sel_col,
    input  logic              in_valid_L,
    input  logic              in_valid_R,
    input  logic              out_valid,
    input  logic              ds_ready,
    output logic              clken,
    output logic              enable,
    output logic [DimW-1:0]   width,
    output logic [RangeW-1:0] range,
    output logic [LrcW-1:0]   lrc_param,
    output logic              postprocessing_sel,
    output logic              sel_col,
    output logic              busy,
    output logic              done,
    output logic              err_timeout,
    output logic [DimW-1:0]   out_row,
    output logic [DimW-1:0]   out_col
);

    localparam int unsigned StallW = $clog2(TIMEOUT + 1);

    if (DWIDTH == 0) begin : g_dwidth_invalid
        $error("post_frame_ctrl: DWIDTH must be nonzero");
    end

    state_e              state_q, state_d;
    logic [DimW-1:0]     width_q, height_q;
    logic [RangeW-1:0]   range_q;
    logic [LrcW-1:0]     lrc_q;
    logic                pp_sel_q, sel_col_q;
    logic                err_q, err_d;
    logic [CntW-1:0]     in_cnt_q, in_cnt_d;
    logic [CntW-1:0]     frame_pix;
    logic [StallW-1:0]   stall_q, stall_d;
    logic                accept_start;
    logic                in_acc, out_acc;
    logic                last_pix, last_done;
    logic                pix_clr;

    // Only the left view paces the frame; the right strobe is not needed here.
    logic unused_in_valid_r;
    assign unused_in_valid_r = in_valid_R;

    assign enable       = (state_q == StRun) || (state_q == StDrain);
    assign busy         = enable || (state_q == StLoad);
    assign clken        = enable && ds_ready;
    assign done         = (state_q == StDone);
    assign accept_start = (state_q == StIdle) && start;
    assign in_acc       = clken && in_valid_L;
    assign out_acc      = clken && out_valid;
    assign last_done    = out_acc && last_pix;
    assign pix_clr      = (state_q == StDone);
    assign frame_pix    = frame_pixels(width_q, height_q);

    always_comb begin
        state_d  = state_q;
        in_cnt_d = in_cnt_q;
        stall_d  = stall_q;
        err_d    = err_q;

        if (in_acc) begin
            in_cnt_d = in_cnt_q + CntW'(1);
        end
        // Stall count only matters while draining; any accepted output restarts it.
        if ((state_q == StDrain) && clken) begin
            stall_d = out_valid ? '0 : stall_q + StallW'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoad;
                    err_d   = 1'b0;
                end
            end
            StLoad: begin
                state_d = ((width_q == '0) || (height_q == '0)) ? StDone : StRun;
            end
            StRun: begin
                if (last_done) begin
                    state_d = StDone;
                end else if (in_cnt_d == frame_pix) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (last_done) begin
                    state_d = StDone;
                end else if (stall_d == StallW'(TIMEOUT)) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                end
            end
            StDone: begin
                state_d  = StIdle;
                in_cnt_d = '0;
                stall_d  = '0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            in_cnt_q <= '0;
            stall_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            in_cnt_q <= in_cnt_d;
            stall_q  <= stall_d;
            err_q    <= err_d;
        end
    end

    // Shadow configuration: captured only on an accepted start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            width_q   <= '0;
            height_q  <= '0;
            range_q   <= '0;
            lrc_q     <= '0;
            pp_sel_q  <= 1'b0;
            sel_col_q <= 1'b0;
        end else if (accept_start) begin
            width_q   <= cfg_width;
            height_q  <= cfg_height;
            range_q   <= cfg_range;
            lrc_q     <= cfg_lrc_param;
            pp_sel_q  <= cfg_pp_sel;
            sel_col_q <= cfg_sel_col;
        end
    end

    post_pix_counter u_pix_counter (
        .clk_i    (clk),
        .rst_ni   (rst),
        .clr_i    (pix_clr),
        .adv_i    (out_acc),
        .width_i  (width_q),
        .height_i (height_q),
        .col_o    (out_col),
        .row_o    (out_row),
        .last_o   (last_pix)
    );

    assign width              = width_q;
    assign range              = range_q;
    assign lrc_param          = lrc_q;
    assign postprocessing_sel = pp_sel_q;
    assign sel_col            = sel_col_q;
    assign err_timeout        = err_q;

endmodule

// File: tb/tb_post_frame_ctrl.sv
// tb_post_frame_ctrl: directed frames followed by randomized traffic, every cycle
// compared against a transaction-level reference model of the frame controller.
module tb_post_frame_ctrl;

    localparam int TO = 16;

    localparam int PIdle  = 0;
    localparam int PLoad  = 1;
    localparam int PRun   = 2;
    localparam int PDrain = 3;
    localparam int PDone  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [10:0] cfg_width = '0;
    logic [10:0] cfg_height = '0;
    logic [8:0]  cfg_range = '0;
    logic [17:0] cfg_lrc_param = '0;
    logic        cfg_pp_sel = 1'b0;
    logic        cfg_sel_col = 1'b0;
    logic        in_valid_L = 1'b0;
    logic        in_valid_R = 1'b0;
    logic        out_valid = 1'b0;
    logic        ds_ready = 1'b1;

    logic        clken, enable, postprocessing_sel, sel_col, busy, done, err_timeout;
    logic [10:0] width, out_row, out_col;
    logic [8:0]  range;
    logic [17:0] lrc_param;

    post_frame_ctrl #(
        .DWIDTH  (16),
        .TIMEOUT (TO)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .cfg_width          (cfg_width),
        .cfg_height         (cfg_height),
        .cfg_range          (cfg_range),
        .cfg_lrc_param      (cfg_lrc_param),
        .cfg_pp_sel         (cfg_pp_sel),
        .cfg_sel_col        (cfg_sel_col),
        .in_valid_L         (in_valid_L),
        .in_valid_R         (in_valid_R),
        .out_valid          (out_valid),
        .ds_ready           (ds_ready),
        .clken              (clken),
        .enable             (enable),
        .width              (width),
        .range              (range),
        .lrc_param          (lrc_param),
        .postprocessing_sel (postprocessing_sel),
        .sel_col            (sel_col),
        .busy               (busy),
        .done               (done),
        .err_timeout        (err_timeout),
        .out_row            (out_row),
        .out_col            (out_col)
    );

    always #5 clk = ~clk;

    // Reference model: frame phase, pixels accepted in/out, stall run length, shadow cfg.
    int m_ph, m_in, m_acc, m_stall;
    bit m_err;
    int sh_w, sh_h, sh_r, sh_l;
    bit sh_pp, sh_sc;

    int errors = 0;
    int checks = 0;
    int done_seen = 0;
    int en_seen = 0;
    int err_seen = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ph = PIdle; m_in = 0; m_acc = 0; m_stall = 0; m_err = 1'b0;
        sh_w = 0; sh_h = 0; sh_r = 0; sh_l = 0; sh_pp = 1'b0; sh_sc = 1'b0;
    endtask

    task automatic check_outputs();
        bit en, bz, ck, dn;
        int tot, idx, row, col;
        en  = (m_ph == PRun) || (m_ph == PDrain);
        bz  = en || (m_ph == PLoad);
        ck  = en && ds_ready;
        dn  = (m_ph == PDone);
        tot = sh_w * sh_h;
        idx = (tot == 0 || m_acc >= tot) ? 0 : m_acc;
        if (sh_w == 0) begin
            row = 0; col = 0;
        end else begin
            col = idx % sh_w; row = idx / sh_w;
        end
        chk("ctrl{clken,enable,busy,done,err}",
            {59'b0, clken, enable, busy, done, err_timeout},
            {59'b0, ck, en, bz, dn, m_err});
        chk("pos{row,col}", {42'b0, out_row, out_col}, {42'b0, 11'(row), 11'(col)});
        chk("shadow_cfg", {24'b0, width, range, lrc_param, postprocessing_sel, sel_col},
            {24'b0, 11'(sh_w), 9'(sh_r), 18'(sh_l), sh_pp, sh_sc});
        if (done) done_seen++;
        if (enable) en_seen++;
        if (err_timeout) err_seen++;
    endtask

    task automatic model_step();
        bit ck, hit;
        int tot;
        if (!rst) begin
            model_reset();
            return;
        end
        ck  = ((m_ph == PRun) || (m_ph == PDrain)) && ds_ready;
        tot = sh_w * sh_h;
        case (m_ph)
            PIdle: if (start) begin
                sh_w = int'(cfg_width); sh_h = int'(cfg_height);
                sh_r = int'(cfg_range); sh_l = int'(cfg_lrc_param);
                sh_pp = cfg_pp_sel; sh_sc = cfg_sel_col;
                m_err = 1'b0; m_ph = PLoad;
            end
            PLoad: m_ph = (tot == 0) ? PDone : PRun;
            PRun, PDrain: begin
                hit = ck && out_valid && (m_acc + 1 == tot);
                if (ck && in_valid_L) m_in++;
                if (ck && out_valid) m_acc++;
                if (m_ph == PDrain && ck) m_stall = out_valid ? 0 : m_stall + 1;
                if (hit) m_ph = PDone;
                else if (m_ph == PRun && m_in == tot) m_ph = PDrain;
                else if (m_ph == PDrain && m_stall == TO) begin
                    m_err = 1'b1; m_ph = PDone;
                end
            end
            PDone: begin
                m_ph = PIdle; m_in = 0; m_acc = 0; m_stall = 0;
            end
            default: m_ph = PIdle;
        endcase
    endtask

    // One clock: inputs are set at the falling edge, outputs checked 1 ns later.
    task automatic tick();
        #1;
        if (!rst) model_reset();
        check_outputs();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic set_cfg(input int w, input int h);
        cfg_width = 11'(w); cfg_height = 11'(h);
        cfg_range = 9'($urandom); cfg_lrc_param = 18'($urandom);
        cfg_pp_sel = 1'($urandom); cfg_sel_col = 1'($urandom);
    endtask

    // Start pulse plus the load cycle.
    task automatic begin_frame();
        start = 1'b1; tick(); start = 1'b0; tick();
    endtask

    initial begin
        model_reset();
        @(negedge clk);

        // Reset with noisy inputs, then release; idle ignores strobes.
        rst = 1'b0; start = 1'b1; in_valid_L = 1'b1; out_valid = 1'b1;
        repeat (2) tick();
        rst = 1'b1; start = 1'b0; in_valid_L = 1'b0; out_valid = 1'b0;
        tick();
        in_valid_L = 1'b1; in_valid_R = 1'b1; out_valid = 1'b1;
        repeat (2) tick();
        in_valid_L = 1'b0; in_valid_R = 1'b0; out_valid = 1'b0;

        // 4x2 frame; cfg_width changed and start re-pulsed mid-frame.
        set_cfg(4, 2);
        done_seen = 0;
        begin_frame();
        cfg_width = 11'd7; start = 1'b1;
        in_valid_L = 1'b1; repeat (8) tick(); in_valid_L = 1'b0; start = 1'b0;
        out_valid = 1'b1; repeat (8) tick(); out_valid = 1'b0;
        chk("f1_no_early_done", 64'(done_seen), 64'd0);
        tick();
        chk("f1_done_after_last", 64'(done_seen), 64'd1);
        tick();
        chk("f1_done_single", 64'(done_seen), 64'd1);
        chk("f1_width_held", 64'(width), 64'd4);

        // ds_ready low for 5 cycles during input and during output.
        set_cfg(4, 2);
        done_seen = 0;
        begin_frame();
        in_valid_L = 1'b1; repeat (3) tick();
        ds_ready = 1'b0; repeat (5) tick(); ds_ready = 1'b1;
        repeat (5) tick(); in_valid_L = 1'b0;
        out_valid = 1'b1; repeat (4) tick();
        ds_ready = 1'b0; repeat (5) tick(); ds_ready = 1'b1;
        repeat (4) tick(); out_valid = 1'b0;
        tick();
        chk("stall_frame_done", 64'(done_seen), 64'd1);

        // Drain timeout after 3 of 8 outputs.
        set_cfg(4, 2);
        done_seen = 0; err_seen = 0;
        begin_frame();
        in_valid_L = 1'b1; repeat (8) tick(); in_valid_L = 1'b0;
        out_valid = 1'b1; repeat (3) tick(); out_valid = 1'b0;
        repeat (TO) tick();
        chk("timeout_not_early", 64'(err_seen), 64'd0);
        tick();
        chk("timeout_err_set", 64'(err_seen), 64'd1);
        chk("timeout_done", 64'(done_seen), 64'd1);
        tick();
        chk("timeout_err_sticky", 64'(err_timeout), 64'd1);

        // Zero height: load then done, never enabled; error cleared by this start.
        set_cfg(5, 0);
        done_seen = 0; en_seen = 0;
        begin_frame();
        tick(); tick();
        chk("zero_h_no_enable", 64'(en_seen), 64'd0);
        chk("zero_h_done", 64'(done_seen), 64'd1);
        chk("zero_h_err_clear", 64'(err_timeout), 64'd0);

        // Reset mid-run, then a fresh full frame.
        set_cfg(4, 2);
        done_seen = 0;
        begin_frame();
        in_valid_L = 1'b1; out_valid = 1'b1; repeat (3) tick();
        rst = 1'b0; repeat (2) tick();
        chk("reset_no_done", 64'(done_seen), 64'd0);
        rst = 1'b1; in_valid_L = 1'b0; out_valid = 1'b0;
        tick();
        set_cfg(4, 2);
        begin_frame();
        in_valid_L = 1'b1; repeat (8) tick(); in_valid_L = 1'b0;
        out_valid = 1'b1; repeat (8) tick(); out_valid = 1'b0;
        tick();
        chk("after_reset_done", 64'(done_seen), 64'd1);

        // Randomized traffic with occasional resets and varying output density.
        for (int c = 0; c < 2500; c++) begin
            rst        = ($urandom_range(0, 299) != 0);
            start      = ($urandom_range(0, 5) == 0);
            set_cfg($urandom_range(0, 5), $urandom_range(0, 4));
            in_valid_L = 1'($urandom_range(0, 1));
            in_valid_R = 1'($urandom_range(0, 1));
            out_valid  = (c % 400 < 300) ? ($urandom_range(0, 3) != 0)
                                         : ($urandom_range(0, 15) == 0);
            ds_ready   = ($urandom_range(0, 4) != 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/post_frame_ctrl.md
POST_FRAME_CTRL -- requirements
Module: post_frame_ctrl

Interface
REQ-001 SHALL have parameter DWIDTH, default 16, disparity word width passed through to the shared package.
REQ-002 SHALL have parameter TIMEOUT, default 4096, maximum consecutive stalled drain cycles before abort.
REQ-003 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  frame start pulse; honoured only in IDLE.
REQ-006 SHALL have ports cfg_width/cfg_height  input  11 each  frame size in pixels/lines.
REQ-007 SHALL have ports cfg_range  input  9, cfg_lrc_param  input  18 (10.8 fixed-point), cfg_pp_sel  input  1, cfg_sel_col  input  1  requested datapath configuration.
REQ-008 SHALL have ports in_valid_L, in_valid_R  input  1 each  disparity-input strobes fed to the post-processing datapath.
REQ-009 SHALL have ports out_valid  input  1  final hole-filled strobe from the datapath; ds_ready  input  1  downstream can accept.
REQ-010 SHALL have ports clken  output  1; enable  output  1; width  output  11; range  output  9; lrc_param  output  18; postprocessing_sel  output  1; sel_col  output  1  datapath control and shadow configuration.
REQ-011 SHALL have ports busy, done, err_timeout  output  1 each; out_row, out_col  output  11 each  current output pixel position.

Function
REQ-012 SHALL implement states IDLE, LOAD, RUN, DRAIN, DONE.
REQ-013 IDLE: start=1 -> LOAD; all cfg_* latched into shadow registers on that same edge; err_timeout cleared.
REQ-014 LOAD (1 cycle): if shadow width==0 or height==0 -> DONE, else -> RUN.
REQ-015 width/range/lrc_param/postprocessing_sel/sel_col SHALL drive shadow values only; cfg_* changes after the start edge have no effect until the next start.
REQ-016 enable=1 and busy=1 in RUN and DRAIN; busy=1 also in LOAD; clken = ds_ready while enable=1, else 0 (combinational).
REQ-017 Input counter (22 bits) SHALL increment on in_valid_L && clken; reaching width*height (22-bit product) -> DRAIN next cycle.
REQ-018 Output column/row counters SHALL advance on out_valid && clken; col wraps width-1 -> 0 with row+1.
REQ-019 Output pixel (row=height-1, col=width-1) accepted -> DONE, in any state RUN or DRAIN; takes priority over the REQ-017 transition in the same cycle.
REQ-020 DRAIN: stall counter increments on cycles with clken=1 and out_valid=0, clears on out_valid; reaching TIMEOUT -> err_timeout=1 (sticky) and -> DONE.
REQ-021 DONE (1 cycle): done=1, clken=0, enable=0; -> IDLE; counters cleared.
REQ-022 start outside IDLE SHALL be ignored.
REQ-023 out_valid or in_valid_* in IDLE SHALL be ignored (no count change).
REQ-024 ds_ready=0 SHALL freeze all counters (clken=0) without changing state.

Reset
REQ-025 rst=0 SHALL asynchronously force IDLE, all counters 0, shadow registers 0, clken/enable/busy/done/err_timeout 0, out_row/out_col 0.
REQ-026 Reset mid-frame SHALL abort without done pulse; the next start begins a fresh frame.

Structure
REQ-027 State encoding, DWIDTH, 11-bit dimension and 18-bit threshold widths SHALL live in shared package post_pkg.
REQ-028 One sub-module post_pix_counter (column/row counter with wrap and last flag) SHALL be used for the output position.

Verification
REQ-029 4x2 frame, ds_ready=1, 8 in_valid_L then 8 out_valid -> DRAIN after 8th input, done high exactly one cycle after 8th output, out_row/out_col sequence 0/0..1/3.
REQ-030 Change cfg_width 4->7 during RUN -> width output stays 4 until done.
REQ-031 ds_ready=0 for 5 cycles mid-frame -> clken=0, counters frozen, frame completes with correct 8 outputs.
REQ-032 TIMEOUT=16, stop out_valid in DRAIN -> err_timeout=1 after 16 stalled cycles, done pulse, err cleared on next start.
REQ-033 cfg_height=0 -> LOAD then DONE, done pulse, enable never asserted.
REQ-034 Assert rst=0 mid-RUN, second start -> all outputs 0 during reset, new frame counts from 0.
